// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button pulse array.
package button_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE         = 2'd0;
    localparam state_t PRESS_WAIT   = 2'd1;
    localparam state_t PRESSED      = 2'd2;
    localparam state_t RELEASE_WAIT = 2'd3;

    localparam int SYNC_STAGES = 2;

    // Bits needed to hold values 0..maxValue.
    function automatic int cnt_width(input int maxValue);
        return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM and press-pulse generator.
// Auto-repeat while held is compiled in only when AUTO_REPEAT_EN is defined.
module button_chan
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic d_out,
    output logic btn_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   level_q, level_d;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // rptPhase_q marks that the initial delay has elapsed and the counter now measures periods.
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
`endif

    assign sync      = sync_q[SYNC_STAGES-1];
    assign d_out     = pulse_q;
    assign btn_level = level_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
`ifdef AUTO_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
`ifdef AUTO_REPEAT_EN
                else if (!rpt_phase_q) begin
                    if (rpt_cnt_q == RPT_DELAY_LAST) begin
                        pulse_d     = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_ONE;
                    end
                end else if (rpt_cnt_q == RPT_PERIOD_LAST) begin
                    pulse_d   = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_ONE;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`endif

endmodule

// File: rtl/button_pulse_array.sv
// NUM_BTN independent debounced push-button channels producing press pulses and levels.
// Define AUTO_REPEAT_EN to enable hold-to-repeat pulses.
module button_pulse_array #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] d_out,
    output logic [NUM_BTN-1:0] btn_level
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : gen_chan
        button_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .btn       (btn[i]),
            .d_out     (d_out[i]),
            .btn_level (btn_level[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_array.sv
// Directed-vector bench for button_pulse_array (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5).
// Row k of a vector table is driven before clock edge k and checked 1 time unit after it.
module tb_button_pulse_array;

    localparam int NUM_BTN = 4;

    typedef struct {
        logic [NUM_BTN-1:0] btn;
        logic [NUM_BTN-1:0] expPulse;
        logic [NUM_BTN-1:0] expLevel;
    } vec_t;

    logic               clk = 1'b0;
    logic               resetN = 1'b1;
    logic [NUM_BTN-1:0] btn = '0;
    logic [NUM_BTN-1:0] dOut;
    logic [NUM_BTN-1:0] btnLevel;

    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs[$];

    button_pulse_array #(
        .NUM_BTN         (NUM_BTN),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk       (clk),
        .reset_n   (resetN),
        .btn       (btn),
        .d_out     (dOut),
        .btn_level (btnLevel)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [NUM_BTN-1:0] value);
        btn = value;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [NUM_BTN-1:0] actual,
                               input logic [NUM_BTN-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s row %0d: got %b expected %b", name, row, actual, expected);
        end
    endtask

    // Holds reset across two edges and releases it 3 units after an edge.
    task automatic doReset(input logic [NUM_BTN-1:0] held);
        btn = held;
        #1 resetN = 1'b0;
        #1;
        checkOutput("reset d_out", 0, dOut, '0);
        checkOutput("reset level", 0, btnLevel, '0);
        repeat (2) @(posedge clk);
        #3 resetN = 1'b1;
    endtask

    task automatic runVectors(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].btn);
            checkOutput({name, " d_out"}, i, dOut, vecs[i].expPulse);
            checkOutput({name, " level"}, i, btnLevel, vecs[i].expLevel);
        end
    endtask

    initial begin
        // Press on btn[0] held 20 cycles, 3-cycle glitch on btn[1].
        doReset('0);
        vecs.delete();
        for (int k = 0; k < 28; k++) begin
            vec_t v;
            v.btn      = {2'b00, (k < 3), (k < 20)};
            v.expPulse = {3'b000, (k == 5)};
            v.expLevel = {3'b000, (k >= 5 && k < 25)};
            vecs.push_back(v);
        end
        runVectors("press_glitch");

        // Release bounce of 2 low cycles on btn[2], then a real release.
        doReset('0);
        vecs.delete();
        for (int k = 0; k < 30; k++) begin
            vec_t v;
            v.btn      = {1'b0, ((k < 10) || (k >= 12 && k < 20)), 2'b00};
            v.expPulse = {1'b0, (k == 5), 2'b00};
            v.expLevel = {1'b0, (k >= 5 && k < 25), 2'b00};
            vecs.push_back(v);
        end
        runVectors("release_bounce");

        // Simultaneous press on btn[0] and btn[3].
        doReset('0);
        vecs.delete();
        for (int k = 0; k < 9; k++) begin
            vec_t v;
            v.btn      = 4'b1001;
            v.expPulse = (k == 5) ? 4'b1001 : 4'b0000;
            v.expLevel = (k >= 5) ? 4'b1001 : 4'b0000;
            vecs.push_back(v);
        end
        runVectors("simultaneous");

        // Asynchronous reset while btn[0] is pressed, then a fresh press after release.
        doReset('0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0001);
        end
        checkOutput("pre_reset level", 7, btnLevel, 4'b0001);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_reset d_out", 0, dOut, '0);
        checkOutput("async_reset level", 0, btnLevel, '0);
        @(posedge clk);
        #3 resetN = 1'b1;
        vecs.delete();
        for (int k = 0; k < 9; k++) begin
            vec_t v;
            v.btn      = 4'b0001;
            v.expPulse = {3'b000, (k == 5)};
            v.expLevel = {3'b000, (k >= 5)};
            vecs.push_back(v);
        end
        runVectors("after_reset");

        // Hold btn[1] for 30 cycles; repeats only when auto-repeat is built in.
        doReset('0);
        vecs.delete();
        for (int k = 0; k < 36; k++) begin
            vec_t v;
            logic pulseBit;
`ifdef AUTO_REPEAT_EN
            pulseBit = (k == 5) || (k == 15) || (k == 20) || (k == 25) || (k == 30);
`else
            pulseBit = (k == 5);
`endif
            v.btn      = {2'b00, (k < 30), 1'b0};
            v.expPulse = {2'b00, pulseBit, 1'b0};
            v.expLevel = {2'b00, (k >= 5 && k < 35), 1'b0};
            vecs.push_back(v);
        end
        runVectors("hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
